// File: rtl/interpol_sched_pkg.sv
// Shared constants and FSM encoding for the interpol_sched scheduler.
package interpol_pkg;
  localparam int SAMPLE_W = 18;
  localparam int UPSAMPLE = 4;
  localparam int PHASE_W  = $clog2(UPSAMPLE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;
endpackage

// File: rtl/interpol_sched_if.sv
// Upstream sample handshake (valid/ready) between a source and interpol_sched.
interface interpol_sched_if;
  logic                                     src_valid;
  logic signed [interpol_pkg::SAMPLE_W-1:0] src_data;
  logic                                     src_ready;

  modport master (output src_valid, output src_data, input src_ready);
  modport slave  (input src_valid, input src_data, output src_ready);
endinterface

// File: rtl/interpol_sched_strobe_gen.sv
// Strobe divider and phase counter: one clken4x every divreg+1 cycles, wrap on phase 3->0.
module strobe_gen
  import interpol_pkg::*;
#(
  parameter int DIVW = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               run,
  input  logic [DIVW-1:0]    divreg,
  output logic               clken4x,
  output logic [PHASE_W-1:0] phase,
  output logic               wrap
);

  logic [DIVW-1:0] divcnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      divcnt  <= '0;
      phase   <= '0;
      clken4x <= 1'b0;
      wrap    <= 1'b0;
    end else if (clear) begin
      divcnt  <= '0;
      phase   <= '0;
      clken4x <= 1'b0;
      wrap    <= 1'b0;
    end else if (!run) begin
      // Armed but not yet running: preset phase so the first strobe wraps to 0.
      divcnt  <= '0;
      phase   <= PHASE_W'(UPSAMPLE - 1);
      clken4x <= 1'b0;
      wrap    <= 1'b0;
    end else if (divcnt == divreg) begin
      divcnt  <= '0;
      phase   <= phase + PHASE_W'(1);
      clken4x <= 1'b1;
      wrap    <= (phase == PHASE_W'(UPSAMPLE - 1));
    end else begin
      divcnt  <= divcnt + DIVW'(1);
      clken4x <= 1'b0;
      wrap    <= 1'b0;
    end
  end

endmodule

// File: rtl/interpol_sched.sv
// Sample scheduler feeding a 4X interpolator; optional underrun counter via
// INTERPOL_SCHED_UNDERRUN_CNT_EN.
module interpol_sched
  import interpol_pkg::*;
#(
  parameter int DIVW = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [DIVW-1:0]            div4,
  interpol_sched_if.slave            src,
  output logic signed [SAMPLE_W-1:0] xkin,
  output logic                       clkenin,
  output logic                       clken4x,
  output logic [PHASE_W-1:0]         phase,
  output logic                       running,
  output logic                       underrun
`ifdef INTERPOL_SCHED_UNDERRUN_CNT_EN
  , output logic [7:0]               underrun_cnt
`endif
);

  state_t                      state;
  logic [DIVW-1:0]             divreg;
  logic signed [SAMPLE_W-1:0]  buf_data;
  logic                        bufv;
  logic                        xfer;
  logic                        sg_clear;
  logic                        sg_run;

  assign src.src_ready = (state != IDLE) && !bufv;
  assign xfer          = src.src_valid && src.src_ready;
  assign running       = (state == RUN);
  assign underrun      = clkenin && !bufv;

  // Dropping enable clears the strobe generator on the same edge the FSM leaves.
  assign sg_clear = (state == IDLE) || !enable;
  assign sg_run   = (state == RUN) && enable;

  strobe_gen #(.DIVW(DIVW)) u_strobe_gen (
    .clock   (clock),
    .reset   (reset),
    .clear   (sg_clear),
    .run     (sg_run),
    .divreg  (divreg),
    .clken4x (clken4x),
    .phase   (phase),
    .wrap    (clkenin)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      divreg   <= '0;
      xkin     <= '0;
      buf_data <= '0;
      bufv     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            divreg <= div4;
            state  <= PRIME;
          end
        end
        PRIME: begin
          if (!enable) begin
            state <= IDLE;
            bufv  <= 1'b0;
          end else if (xfer) begin
            xkin  <= src.src_data;
            state <= RUN;
          end
        end
        RUN: begin
          if (!enable) begin
            state <= IDLE;
            bufv  <= 1'b0;
          end else if (clkenin && bufv) begin
            xkin <= buf_data;
            bufv <= 1'b0;
          end else if (xfer) begin
            buf_data <= src.src_data;
            bufv     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INTERPOL_SCHED_UNDERRUN_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      underrun_cnt <= '0;
    end else if (state == IDLE && enable) begin
      underrun_cnt <= '0;
    end else if (underrun && underrun_cnt != 8'hFF) begin
      underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/interpol_sched.md
INTERPOL_SCHED -- requirements
Module: interpol_sched

Interface
REQ-001 The module SHALL have parameter DIVW, default 8, giving the width of the strobe-period divider.
REQ-002 The module SHALL have port clock, input, 1 bit, master clock; all logic on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit, master reset, asynchronous and active-low.
REQ-004 The module SHALL have port enable, input, 1 bit, run request; high starts and keeps scheduling, low stops.
REQ-005 The module SHALL have port div4, input, DIVW bits, clock cycles between clken4x strobes minus 1.
REQ-006 The module SHALL have ports src_valid (input, 1), src_data (input, 18, signed) and src_ready (output, 1), forming the upstream sample handshake.
REQ-007 The module SHALL have ports xkin (output, 18, signed), clkenin (output, 1) and clken4x (output, 1), which drive the 4X interpolator.
REQ-008 The module SHALL have ports phase (output, 2, position of the current clken4x strobe within the input period), running (output, 1), underrun (output, 1, one-cycle pulse).

Function
REQ-009 The FSM SHALL have three states: IDLE, PRIME (waiting for the first sample) and RUN.
REQ-010 In IDLE, a sampled enable=1 SHALL latch div4 into divreg and move the FSM to PRIME; div4 changes outside IDLE SHALL be ignored.
REQ-011 In PRIME, the FSM SHALL hold src_ready=1, and the first src_valid&&src_ready transfer SHALL load xkin and move the FSM to RUN with divcnt=0 and phase=3.
REQ-012 In RUN, divcnt SHALL count up to divreg, then assert clken4x for one cycle, clear divcnt and increment phase modulo 4; divreg=0 SHALL give clken4x on every cycle.
REQ-013 The clkenin output SHALL be asserted in exactly the clken4x cycle where phase wraps 3->0, and never otherwise.
REQ-014 The module SHALL have a one-entry buffer (buf, bufv); src_ready SHALL equal !bufv in RUN and PRIME, and 0 in IDLE.
REQ-015 In a clkenin cycle with bufv=1, xkin SHALL take buf on the next edge and bufv SHALL clear; xkin SHALL be held stable across the whole clkenin cycle.
REQ-016 A handshake transfer in the same cycle as buffer consumption SHALL be impossible, since src_ready=0 whenever bufv=1; a transfer in a cycle with bufv=0 SHALL set bufv on the next edge.
REQ-017 In a clkenin cycle with bufv=0 (underrun), xkin SHALL hold its previous value, clkenin SHALL still assert, and underrun SHALL pulse in that same cycle.
REQ-018 enable=0 sampled in PRIME or RUN SHALL return the FSM to IDLE on the next edge, stop strobes immediately, clear bufv, divcnt and phase, and hold xkin.
REQ-019 The running output SHALL be 1 exactly when the FSM is in RUN.

Reset
REQ-020 Asserting reset SHALL asynchronously force: FSM=IDLE, xkin=0, buf=0, bufv=0, divcnt=0, divreg=0, phase=0, clkenin=0, clken4x=0, underrun=0, running=0, src_ready=0.
REQ-021 Reset deassertion SHALL take effect at the next clock edge; mid-operation reset SHALL discard any buffered sample.

Configuration
REQ-022 With INTERPOL_SCHED_UNDERRUN_CNT_EN defined, the module SHALL add output underrun_cnt (8 bits), which increments on each underrun pulse, saturates at 255, clears on reset, and clears on the IDLE->PRIME transition.
REQ-023 Without INTERPOL_SCHED_UNDERRUN_CNT_EN, the underrun_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-024 The state encoding (IDLE=0, PRIME=1, RUN=2), the sample width constant 18 and the upsample factor constant 4 SHALL live in the shared package interpol_pkg.
REQ-025 The divider and phase counter SHALL form one sub-module, strobe_gen (inputs: clear, run, divreg; outputs: clken4x, phase, wrap); everything else SHALL be in the top level.

Verification
REQ-026 The bench SHALL drive div4=9, enable=1, with a source that always has a sample ready -> clken4x every 10 clocks, clkenin every 40 clocks coincident with phase 3->0, no underrun.
REQ-027 The bench SHALL drive div4=0 with samples 100, -200, 300 -> clken4x every cycle, clkenin every 4 cycles, xkin steps 100, -200, 300 on successive clkenin.
REQ-028 The bench SHALL withhold src_valid for one input period after a sample of 500 -> underrun pulses once, xkin stays 500, and clkenin still fires.
REQ-029 The bench SHALL drop enable mid-RUN with bufv=1 -> clken4x/clkenin stop the next cycle, running=0, src_ready=0; re-enabling with div4=3 -> PRIME, then clken4x every 4 clocks.
REQ-030 The bench SHALL assert reset between a clken4x edge and the following clock edge -> all outputs zero immediately, without waiting for a clock edge.
REQ-031 With INTERPOL_SCHED_UNDERRUN_CNT_EN defined, the bench SHALL force 300 consecutive underruns -> underrun_cnt=255, then 0 after a disable/enable cycle.
